// File: rtl/demux_pkg.sv
// Shared constants for the buffered 1-to-4 demultiplexer.
package demux_pkg;

  localparam int NUM_CH = 4;
  localparam int SEL_W  = 2;
  localparam int CNT_W  = 8;

  typedef logic [SEL_W-1:0] sel_t;

  localparam sel_t CH0 = 2'b00;
  localparam sel_t CH1 = 2'b01;
  localparam sel_t CH2 = 2'b10;
  localparam sel_t CH3 = 2'b11;

endpackage

// File: rtl/demux_slot.sv
// One-entry output slot: a full flag plus a data register with a
// valid/ready drain side. A write on the same edge as a drain keeps the
// slot full with the new word, giving one word per cycle of throughput.
module demux_slot #(
  parameter int n = 3
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         wr_en,
  input  logic [n-1:0] wr_data,
  input  logic         rd_ready,
  input  logic         flush,
  output logic         full,
  output logic [n-1:0] data
);

  // Occupancy: flush wins, then refill, then drain.
  always_ff @(posedge clk or posedge reset) begin
    if (reset)
      full <= 1'b0;
    else if (flush)
      full <= 1'b0;
    else if (wr_en)
      full <= 1'b1;
    else if (full && rd_ready)
      full <= 1'b0;
  end

  // Data register only changes on an accepted write; it is never cleared by
  // flush or drain, so consumers must qualify it with the full flag.
  always_ff @(posedge clk or posedge reset) begin
    if (reset)
      data <= '0;
    else if (wr_en && !flush)
      data <= wr_data;
  end

endmodule

// File: rtl/demux_1x4_nbits_buf.sv
// Buffered 1-to-4 demultiplexer for n-bit words. Each channel owns a
// one-entry slot with a valid/ready handshake. Optional per-channel 8-bit
// transfer counters are enabled by defining DEMUX_1X4_COUNT_EN.
module demux_1x4_nbits_buf
  import demux_pkg::*;
#(
  parameter int n = 3
) (
  input  logic         clk,
  input  logic         reset,
  input  logic [n-1:0] w,
  input  logic [1:0]   s,
  input  logic         in_valid,
  output logic         in_ready,
  input  logic         flush,
  output logic [n-1:0] f0,
  output logic [n-1:0] f1,
  output logic [n-1:0] f2,
  output logic [n-1:0] f3,
  output logic         v0,
  output logic         v1,
  output logic         v2,
  output logic         v3,
  input  logic         r0,
  input  logic         r1,
  input  logic         r2,
`ifdef DEMUX_1X4_COUNT_EN
  input  logic         r3,
  output logic [7:0]   c0,
  output logic [7:0]   c1,
  output logic [7:0]   c2,
  output logic [7:0]   c3
`else
  input  logic         r3
`endif
);

  logic [NUM_CH-1:0] full;
  logic [NUM_CH-1:0] rdy;
  logic [NUM_CH-1:0] wr_en;
  logic [n-1:0]      data [NUM_CH];
  logic              accept;

  assign rdy = {r3, r2, r1, r0};

  // Ready depends only on the selected slot: free, or draining this edge.
  assign in_ready = ~flush & (~full[s] | rdy[s]);
  assign accept   = in_valid & in_ready;

  // Select decode: one-hot write enable for the targeted slot.
  always_comb begin
    wr_en = '0;
    case (sel_t'(s))
      CH0:     wr_en[0] = accept;
      CH1:     wr_en[1] = accept;
      CH2:     wr_en[2] = accept;
      CH3:     wr_en[3] = accept;
      default: wr_en    = '0;
    endcase
  end

  for (genvar k = 0; k < NUM_CH; k++) begin : g_slot
    demux_slot #(.n(n)) u_slot (
      .clk      (clk),
      .reset    (reset),
      .wr_en    (wr_en[k]),
      .wr_data  (w),
      .rd_ready (rdy[k]),
      .flush    (flush),
      .full     (full[k]),
      .data     (data[k])
    );
  end

  assign v0 = full[0];
  assign v1 = full[1];
  assign v2 = full[2];
  assign v3 = full[3];
  assign f0 = data[0];
  assign f1 = data[1];
  assign f2 = data[2];
  assign f3 = data[3];

`ifdef DEMUX_1X4_COUNT_EN
  logic [CNT_W-1:0] cnt [NUM_CH];

  // Count output transfers per channel; wraps naturally, flush clears first.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      for (int k = 0; k < NUM_CH; k++) cnt[k] <= '0;
    end else if (flush) begin
      for (int k = 0; k < NUM_CH; k++) cnt[k] <= '0;
    end else begin
      for (int k = 0; k < NUM_CH; k++)
        if (full[k] && rdy[k]) cnt[k] <= cnt[k] + CNT_W'(1);
    end
  end

  assign c0 = cnt[0];
  assign c1 = cnt[1];
  assign c2 = cnt[2];
  assign c3 = cnt[3];
`endif

endmodule

// File: tb/tb_demux_1x4_nbits_buf.sv
// Directed testbench for demux_1x4_nbits_buf (n=3). Counter checks are
// compiled in only when DEMUX_1X4_COUNT_EN is defined.
module tb_demux_1x4_nbits_buf;

  logic       clk = 1'b0;
  logic       reset;
  logic [2:0] w;
  logic [1:0] s;
  logic       in_valid;
  logic       in_ready;
  logic       flush;
  logic [2:0] f0, f1, f2, f3;
  logic       v0, v1, v2, v3;
  logic       r0, r1, r2, r3;
`ifdef DEMUX_1X4_COUNT_EN
  logic [7:0] c0, c1, c2, c3;
`endif

  int tests_run    = 0;
  int tests_failed = 0;

  always #5 clk = ~clk;

  demux_1x4_nbits_buf #(.n(3)) dut (
    .clk(clk), .reset(reset), .w(w), .s(s), .in_valid(in_valid),
    .in_ready(in_ready), .flush(flush),
    .f0(f0), .f1(f1), .f2(f2), .f3(f3),
    .v0(v0), .v1(v1), .v2(v2), .v3(v3),
    .r0(r0), .r1(r1), .r2(r2),
`ifdef DEMUX_1X4_COUNT_EN
    .r3(r3), .c0(c0), .c1(c1), .c2(c2), .c3(c3)
`else
    .r3(r3)
`endif
  );

  // Advance one edge and settle; inputs change only here, away from edges.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    in_valid = 1'b0; w = '0; s = '0; flush = 1'b0;
  endtask

  task automatic test_reset();
    // power-on reset
    reset = 1'b1; idle(); {r3, r2, r1, r0} = 4'b0000;
    tick(); tick();
    reset = 1'b0;
    tick();
    tests_run++;
    if ({v3, v2, v1, v0} !== 4'b0000 || {f3, f2, f1, f0} !== 12'h000) begin
      tests_failed++; $display("FAIL por_state v=%b f=%h expected v=0000 f=000", {v3, v2, v1, v0}, {f3, f2, f1, f0});
    end
    // fill slots 0 and 2 with consumers stalled
    in_valid = 1'b1; w = 3'd5; s = 2'b00; tick();
    w = 3'd6; s = 2'b10; tick();
    in_valid = 1'b0;
    tests_run++;
    if ({v3, v2, v1, v0} !== 4'b0101 || f0 !== 3'd5 || f2 !== 3'd6) begin
      tests_failed++; $display("FAIL rst_prefill v=%b f0=%0d f2=%0d expected v=0101 f0=5 f2=6", {v3, v2, v1, v0}, f0, f2);
    end
    // reset between edges: must clear at once
    #2 reset = 1'b1;
    #1;
    tests_run++;
    if ({v3, v2, v1, v0} !== 4'b0000 || {f3, f2, f1, f0} !== 12'h000) begin
      tests_failed++; $display("FAIL rst_async v=%b f=%h expected v=0000 f=000", {v3, v2, v1, v0}, {f3, f2, f1, f0});
    end
    tick();
    reset = 1'b0;
    tick();
    tests_run++;
    if (in_ready !== 1'b1) begin
      tests_failed++; $display("FAIL rst_in_ready got %b expected 1", in_ready);
    end
  endtask

  task automatic test_routing();
    logic [2:0] wv [4];
    logic [2:0] fv;
    logic [3:0] vv;
    wv[0] = 3'd5; wv[1] = 3'd3; wv[2] = 3'd6; wv[3] = 3'd7;
    {r3, r2, r1, r0} = 4'b1111;
    for (int k = 0; k < 4; k++) begin
      in_valid = 1'b1; w = wv[k]; s = 2'(k);
      #1;
      tests_run++;
      if (in_ready !== 1'b1) begin
        tests_failed++; $display("FAIL route_ready ch%0d got %b expected 1", k, in_ready);
      end
      tick();
      case (k)
        0: fv = f0; 1: fv = f1; 2: fv = f2; default: fv = f3;
      endcase
      vv = {v3, v2, v1, v0};
      tests_run++;
      if (fv !== wv[k] || vv !== 4'(1 << k)) begin
        tests_failed++; $display("FAIL route_ch%0d f=%0d v=%b expected f=%0d v=%b", k, fv, vv, wv[k], 4'(1 << k));
      end
    end
    idle();
    tick();
    tests_run++;
    if ({v3, v2, v1, v0} !== 4'b0000 || f3 !== 3'd7) begin
      tests_failed++; $display("FAIL route_drain v=%b f3=%0d expected v=0000 f3=7", {v3, v2, v1, v0}, f3);
    end
  endtask

  task automatic test_backpressure();
    {r3, r2, r1, r0} = 4'b1101;
    in_valid = 1'b1; w = 3'd4; s = 2'b01;
    tick();
    w = 3'd2;
    #1;
    tests_run++;
    if (v1 !== 1'b1 || f1 !== 3'd4 || in_ready !== 1'b0) begin
      tests_failed++; $display("FAIL bp_hold v1=%b f1=%0d in_ready=%b expected 1 4 0", v1, f1, in_ready);
    end
    tick();
    tests_run++;
    if (v1 !== 1'b1 || f1 !== 3'd4) begin
      tests_failed++; $display("FAIL bp_stable v1=%b f1=%0d expected 1 4", v1, f1);
    end
    r1 = 1'b1;
    #1;
    tests_run++;
    if (in_ready !== 1'b1) begin
      tests_failed++; $display("FAIL bp_release_ready got %b expected 1", in_ready);
    end
    tick();
    in_valid = 1'b0;
    tests_run++;
    if (v1 !== 1'b1 || f1 !== 3'd2) begin
      tests_failed++; $display("FAIL bp_refill v1=%b f1=%0d expected 1 2", v1, f1);
    end
    tick();
    tests_run++;
    if (v1 !== 1'b0 || f1 !== 3'd2) begin
      tests_failed++; $display("FAIL bp_drain v1=%b f1=%0d expected 0 2", v1, f1);
    end
  endtask

  task automatic test_independence();
    {r3, r2, r1, r0} = 4'b0000;
    in_valid = 1'b1; w = 3'd6; s = 2'b01;
    tick();
    w = 3'd1; s = 2'b11;
    #1;
    tests_run++;
    if (in_ready !== 1'b1) begin
      tests_failed++; $display("FAIL indep_ready got %b expected 1", in_ready);
    end
    tick();
    in_valid = 1'b0;
    tests_run++;
    if (v3 !== 1'b1 || f3 !== 3'd1 || v1 !== 1'b1 || f1 !== 3'd6) begin
      tests_failed++; $display("FAIL indep_state v3=%b f3=%0d v1=%b f1=%0d expected 1 1 1 6", v3, f3, v1, f1);
    end
    // drain one channel while writing another
    r1 = 1'b1; in_valid = 1'b1; w = 3'd3; s = 2'b00;
    tick();
    idle();
    tests_run++;
    if ({v3, v2, v1, v0} !== 4'b1001 || f0 !== 3'd3) begin
      tests_failed++; $display("FAIL indep_mixed v=%b f0=%0d expected v=1001 f0=3", {v3, v2, v1, v0}, f0);
    end
    {r3, r2, r1, r0} = 4'b1111;
    tick();
  endtask

  task automatic test_flush();
    {r3, r2, r1, r0} = 4'b0000;
    in_valid = 1'b1; w = 3'd2; s = 2'b00; tick();
    w = 3'd5; s = 2'b11; tick();
    tests_run++;
    if ({v3, v2, v1, v0} !== 4'b1001) begin
      tests_failed++; $display("FAIL flush_prefill v=%b expected 1001", {v3, v2, v1, v0});
    end
    // flush even with the target's consumer ready: flush wins
    r0 = 1'b1; flush = 1'b1; w = 3'd7; s = 2'b00;
    #1;
    tests_run++;
    if (in_ready !== 1'b0) begin
      tests_failed++; $display("FAIL flush_in_ready got %b expected 0", in_ready);
    end
    tick();
    idle();
    tests_run++;
    if ({v3, v2, v1, v0} !== 4'b0000 || f0 !== 3'd2 || f3 !== 3'd5) begin
      tests_failed++; $display("FAIL flush_state v=%b f0=%0d f3=%0d expected v=0000 f0=2 f3=5", {v3, v2, v1, v0}, f0, f3);
    end
    {r3, r2, r1, r0} = 4'b1111;
  endtask

`ifdef DEMUX_1X4_COUNT_EN
  task automatic test_counters();
    {r3, r2, r1, r0} = 4'b1111;
    in_valid = 1'b1; s = 2'b10;
    for (int i = 0; i < 257; i++) begin
      w = 3'(i);
      tick();
    end
    idle();
    tick();
    tests_run++;
    if (c2 !== 8'd1 || c0 !== 8'd0 || c1 !== 8'd0 || c3 !== 8'd0) begin
      tests_failed++; $display("FAIL cnt_wrap c0=%0d c1=%0d c2=%0d c3=%0d expected 0 0 1 0", c0, c1, c2, c3);
    end
    // flush during a same-edge drain on channel 0
    r0 = 1'b0; in_valid = 1'b1; s = 2'b00; w = 3'd1; tick();
    idle(); r0 = 1'b1; flush = 1'b1;
    tick();
    flush = 1'b0;
    tests_run++;
    if ({c3, c2, c1, c0} !== 32'h0 || v0 !== 1'b0) begin
      tests_failed++; $display("FAIL cnt_flush c=%h v0=%b expected 00000000 0", {c3, c2, c1, c0}, v0);
    end
  endtask
`endif

  initial begin
    test_reset();
    test_routing();
    test_backpressure();
    test_independence();
    test_flush();
`ifdef DEMUX_1X4_COUNT_EN
    test_counters();
`endif
    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule

// File: doc/demux_1x4_nbits_buf.md
Name: demux_1x4_nbits_buf

Overview:
Buffered 1-to-4 demultiplexer for n-bit words, the inverse of the team's 4x1 n-bit mux. It takes one input stream with a 2-bit select and routes each word to one of four output channels.
- Each channel has a one-entry output register and a valid/ready handshake.
- Sits between a single producer and four independent consumers.

Parameters:
- n, 3, data width of input word and each output word.

Ports:
- clk  input  1  rising-edge clock.
- reset  input  1  asynchronous, active-high reset.
- w  input  n  input data word.
- s  input  2  destination select: 00 routes to f0, 01 to f1, 10 to f2, 11 to f3.
- in_valid  input  1  w/s are valid this cycle.
- in_ready  output  1  block accepts w/s this cycle.
- flush  input  1  synchronous clear of all four output slots.
- f0, f1, f2, f3  output  n each  channel data.
- v0, v1, v2, v3  output  1 each  channel data valid.
- r0, r1, r2, r3  input  1 each  channel consumer ready.

Behaviour:
- Reset (asynchronous, active-high):
  - all vK=0, all fK=0.
  - Takes effect immediately, even mid-transfer; buffered words are discarded.
- Each channel K has a one-entry slot: full flag (drives vK) and data register (drives fK).
- Acceptance: in_ready = ~flush & (~full[s] | rK where K=s). This is combinational on s and rK.
- Input transfer: in_valid & in_ready at a rising edge. Write w into slot s and set full[s]=1.
- Output transfer on channel K: vK & rK at a rising edge. Clear full[K] unless the same edge writes slot K.
- Latency: a word accepted at edge t appears on fK with vK=1 after edge t (1-cycle latency). No combinational path from w to fK.
- Simultaneous drain and refill of the same slot at one edge:
  - the slot stays full and takes the new word;
  - this gives full throughput of one word/cycle on a single channel whose consumer holds rK=1.
- Input writing slot A while slot B≠A drains: both happen independently.
- Full slot, consumer not ready, new word targets it: in_ready=0, and the producer must hold w/s/in_valid stable.
- Words targeting other, non-full slots are unaffected; ready depends only on the selected slot.
- Stability: fK and vK stay stable while vK=1 & rK=0.
- fK holds its last value after drain; consumers must qualify fK with vK.
- flush=1:
  - all full flags clear at the edge;
  - no input accepted that cycle;
  - fK registers are not cleared;
  - flush has priority over any simultaneous transfer.
- in_valid=0: s and w are don't-care; no state change except drains.
- Ordering per channel is preserved trivially (depth 1). No cross-channel ordering guarantee.

Optional Feature:
- Macro: DEMUX_1X4_COUNT_EN.
- When defined:
  - adds output ports c0..c3, 8 bits each;
  - cK increments on every output transfer of channel K and wraps from 255 to 0;
  - reset and flush clear all counters to 0;
  - flush takes priority over a same-edge increment.
- When undefined: ports and counters are absent; behaviour is otherwise identical.

Decomposition:
- Package demux_pkg:
  - constant NUM_CH=4 and SEL_W=2;
  - localparam-style select encodings CH0..CH3 = 2'b00..2'b11;
  - constant CNT_W=8.
- Sub-module demux_slot:
  - one-entry register with wr_en, wr_data, rd_ready, flush, full, data;
  - parameter n;
  - instantiated four times;
  - the top level contains only select decode, in_ready mux and optional counters.

Test Plan:
- Reset mid-operation: fill slots 0 and 2, assert reset between edges -> v0..v3=0 and f0..f3=0 immediately, in_ready=1 after release.
- Routing, n=3, all rK=1: send w=5,s=00; w=3,s=01; w=6,s=10; w=7,s=11 back-to-back -> f0=5, f1=3, f2=6, f3=7, each valid exactly one cycle after acceptance, in_ready stays 1.
- Backpressure: r1=0, send w=4,s=01, then w=2,s=01 -> first word held on f1 with v1=1, in_ready=0 for the second. Raise r1 -> same-edge drain/refill, f1=2 next cycle.
- Independence: r1=0 with slot 1 full, send w=1,s=11 -> accepted, f3=1, v3=1; slot 1 unchanged.
- Flush: slots 0 and 3 full, assert flush with in_valid=1,s=00 -> in_ready=0, all vK=0 next cycle, no write.
- Counters (DEMUX_1X4_COUNT_EN): 257 transfers on channel 2 -> c2=1, c0=c1=c3=0; flush -> all 0.
